pattern_buffer: RTL and testbench
=================================

PATTERN_BUFFER -- requirements
Module: pattern_buffer

Interface
REQ-001 SHALL have parameters: D_WIDTH, default 8, bits per lane; LANES, default 2, lanes per field (lane 0 = low, lane 1 = high); BUFP_WIDTH, default 3, bank-select bits; FIELDP_WIDTH, default 5, field-select bits.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  sole clock, rising edge
 reset  in  1  synchronous, active-low reset
 rd_adr  in  BUFP_WIDTH+FIELDP_WIDTH  PAT read address {bank, field}
 rd_data  out  LANES*D_WIDTH  registered read data, lane k at bits [k*D_WIDTH +: D_WIDTH]
 wr_adr  in  BUFP_WIDTH+FIELDP_WIDTH  PAT write address {bank, field}
 wr_en  in  LANES  per-lane PAT write enable
 wr_data  in  D_WIDTH  PAT write byte, copied to every enabled lane
 load_start  in  1  one-cycle pulse; begins host bank fill
 load_bank  in  BUFP_WIDTH  bank to fill, sampled with load_start
 load_valid  in  1  host word valid
 load_data  in  LANES*D_WIDTH  host word, all lanes
 load_ready  out  1  host word accepted when load_valid && load_ready
 load_busy  out  1  fill in progress
 load_done  out  1  one-cycle pulse after final word written
REQ-003 One clock and one reset only; reset is synchronous and active-low.

Function
REQ-004 Storage SHALL be 2^BUFP_WIDTH banks x 2^FIELDP_WIDTH fields x LANES x D_WIDTH bits.
REQ-005 Read latency SHALL be one cycle: rd_data at edge N+1 reflects rd_adr sampled at edge N.
REQ-006 Same-cycle read and write to the same address SHALL be write-first per lane: enabled lanes return the new value; other lanes return the stored value.
REQ-007 PAT write SHALL update only lanes with wr_en[k]=1 at wr_adr; wr_en=0 SHALL leave memory unchanged.
REQ-008 FSM states SHALL be IDLE, FILL, DONE.
REQ-009 IDLE: load_start=1 SHALL latch load_bank, clear the field counter to 0, and go to FILL.
REQ-010 FILL: on each accepted word, SHALL write load_data to all lanes of {bank, counter} and increment the counter.
REQ-011 FILL: accepting the word at field 2^FIELDP_WIDTH-1 SHALL go to DONE; the counter SHALL wrap to 0.
REQ-012 DONE SHALL last exactly one cycle with load_done=1, then return to IDLE.
REQ-013 load_busy SHALL be 1 in FILL and DONE, and 0 in IDLE.
REQ-014 load_ready SHALL be 1 only in FILL, and only when no PAT write targets the latched bank that cycle (|wr_en && wr_adr bank == latched bank); PAT writes always win.
REQ-015 load_start outside IDLE SHALL be ignored.
REQ-016 Host writes SHALL also be write-first for a same-cycle PAT read of the same address.
REQ-017 load_valid without load_ready SHALL have no effect; the word is held by the host.

Reset
REQ-018 reset=0 at a rising edge SHALL force: state IDLE, counter 0, latched bank 0, rd_data 0, load_ready 0, load_busy 0, load_done 0.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 Reset during FILL SHALL abandon the fill; fields already written keep their values and no load_done is produced.

Structure
REQ-021 A shared package pattern_buffer_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-022 One sub-module, pattern_buffer_ctrl (FSM, counter, load_ready logic), SHALL be instantiated; storage and read path SHALL stay in pattern_buffer.

Verification
REQ-023 Write then read: wr_adr=0x25, wr_en=2'b01, wr_data=0xA5, then rd_adr=0x25 -> rd_data[7:0]=0xA5 one cycle later; lane 1 unchanged.
REQ-024 Bypass: rd_adr=wr_adr=0x10, wr_en=2'b11, wr_data=0x3C in the same cycle -> next-cycle rd_data=0x3C3C.
REQ-025 Full fill: load_start with load_bank=3, then 32 valid words i*0x0101 -> load_done pulses once, one cycle after word 31; reading bank 3 field i returns i*0x0101.
REQ-026 Conflict: during a fill of bank 3, a PAT write to bank 3 -> load_ready=0 that cycle, word not consumed, counter unchanged; a PAT write to bank 2 -> load_ready=1.
REQ-027 Reset mid-fill after 10 words -> load_busy=0 next cycle, no load_done; fields 0-9 retain their data; a new load_start is accepted.
REQ-028 load_start pulsed during FILL -> ignored; latched bank and counter unchanged.

Source files
------------

// File: rtl/pattern_buffer_pkg.sv
// Shared types and default sizing for the pattern buffer and its host-fill controller.
package pattern_buffer_pkg;

  localparam int DEF_D_WIDTH      = 8;
  localparam int DEF_LANES        = 2;
  localparam int DEF_BUFP_WIDTH   = 3;
  localparam int DEF_FIELDP_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_buffer_ctrl.sv
// Host bank-fill sequencer: latches the target bank, walks the field counter and
// yields to PAT writes aimed at the same bank.
module pattern_buffer_ctrl
  import pattern_buffer_pkg::*;
#(
  parameter int BUFP_WIDTH   = DEF_BUFP_WIDTH,
  parameter int FIELDP_WIDTH = DEF_FIELDP_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_start,
  input  logic [BUFP_WIDTH-1:0]              load_bank,
  input  logic                               load_valid,
  input  logic                               pat_wr,
  input  logic [BUFP_WIDTH-1:0]              pat_bank,
  output logic                               load_ready,
  output logic                               load_busy,
  output logic                               load_done,
  output logic                               host_we,
  output logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] host_adr
);

  state_t                  state_r, state_s;
  logic [BUFP_WIDTH-1:0]   bank_r, bank_s;
  logic [FIELDP_WIDTH-1:0] cnt_r, cnt_s;
  logic                    ready_s;
  logic                    busy_s;
  logic                    done_s;

  // State, latched bank and field counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      bank_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      bank_r  <= bank_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and handshake decode; a held reset also blocks host writes.
  always_comb begin
    state_s = state_r;
    bank_s  = bank_r;
    cnt_s   = cnt_r;
    ready_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_start) begin
          state_s = FILL;
          bank_s  = load_bank;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        busy_s  = 1'b1;
        ready_s = reset & ~(pat_wr && (pat_bank == bank_r));
        if (load_valid && ready_s) begin
          cnt_s = cnt_r + FIELDP_WIDTH'(1);
          if (cnt_r == {FIELDP_WIDTH{1'b1}}) begin
            state_s = DONE;
          end else begin
            state_s = FILL;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE: begin
        busy_s  = 1'b1;
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign load_ready = ready_s;
  assign load_busy  = busy_s;
  assign load_done  = done_s;
  assign host_we    = load_valid & ready_s;
  assign host_adr   = {bank_r, cnt_r};

endmodule

// File: rtl/pattern_buffer.sv
// Banked multi-lane pattern store with per-lane PAT writes, a write-first
// registered read port and a host bank-fill port.
module pattern_buffer
  import pattern_buffer_pkg::*;
#(
  parameter int D_WIDTH      = DEF_D_WIDTH,
  parameter int LANES        = DEF_LANES,
  parameter int BUFP_WIDTH   = DEF_BUFP_WIDTH,
  parameter int FIELDP_WIDTH = DEF_FIELDP_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] rd_adr,
  output logic [LANES*D_WIDTH-1:0]           rd_data,
  input  logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] wr_adr,
  input  logic [LANES-1:0]                   wr_en,
  input  logic [D_WIDTH-1:0]                 wr_data,
  input  logic                               load_start,
  input  logic [BUFP_WIDTH-1:0]              load_bank,
  input  logic                               load_valid,
  input  logic [LANES*D_WIDTH-1:0]           load_data,
  output logic                               load_ready,
  output logic                               load_busy,
  output logic                               load_done
);

  localparam int ADR_WIDTH = BUFP_WIDTH + FIELDP_WIDTH;
  localparam int DEPTH     = 1 << ADR_WIDTH;

  logic [LANES*D_WIDTH-1:0] mem_r [DEPTH];
  logic [LANES*D_WIDTH-1:0] base_s;
  logic [LANES*D_WIDTH-1:0] rd_next_s;
  logic                     host_we;
  logic [ADR_WIDTH-1:0]     host_adr;

  pattern_buffer_ctrl #(
    .BUFP_WIDTH   (BUFP_WIDTH),
    .FIELDP_WIDTH (FIELDP_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_bank  (load_bank),
    .load_valid (load_valid),
    .pat_wr     (|wr_en),
    .pat_bank   (wr_adr[ADR_WIDTH-1:FIELDP_WIDTH]),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .host_we    (host_we),
    .host_adr   (host_adr)
  );

  // Storage; host and PAT writes never share a bank in the same cycle.
  always_ff @(posedge clk) begin
    if (host_we) begin
      mem_r[host_adr] <= load_data;
    end
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) begin
        mem_r[wr_adr][k*D_WIDTH +: D_WIDTH] <= wr_data;
      end
    end
  end

  // Write-first read: same-address host word, then per-lane PAT byte, override storage.
  always_comb begin
    if (host_we && (host_adr == rd_adr)) begin
      base_s = load_data;
    end else begin
      base_s = mem_r[rd_adr];
    end
    rd_next_s = base_s;
    for (int k = 0; k < LANES; k++) begin
      rd_next_s[k*D_WIDTH +: D_WIDTH] = (wr_en[k] && (wr_adr == rd_adr)) ?
                                        wr_data : base_s[k*D_WIDTH +: D_WIDTH];
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next_s;
    end
  end

endmodule

// File: tb/tb_pattern_buffer.sv
// Directed self-checking bench for pattern_buffer with default parameters.
module tb_pattern_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rd_adr;
  logic [15:0] rd_data;
  logic [7:0]  wr_adr;
  logic [1:0]  wr_en;
  logic [7:0]  wr_data;
  logic        load_start;
  logic [2:0]  load_bank;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;

  int pass_cnt = 0;
  int total    = 0;

  pattern_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .rd_adr     (rd_adr),
    .rd_data    (rd_data),
    .wr_adr     (wr_adr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .load_start (load_start),
    .load_bank  (load_bank),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input logic [7:0] adr, input logic [15:0] exp, input string name);
    rd_adr = adr;
    step();
    total++;
    if (rd_data !== exp) $display("FAIL %s adr=%h: got %h expected %h", name, adr, rd_data, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; rd_adr = 8'h00; wr_adr = 8'h00; wr_en = 2'b00; wr_data = 8'h00;
    load_start = 1'b0; load_bank = 3'd0; load_valid = 1'b0; load_data = 16'h0000;
    step(); step();
    total++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data: got %h expected 0000", rd_data); else pass_cnt++;
    total++; if (load_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", load_busy); else pass_cnt++;
    total++; if (load_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", load_ready); else pass_cnt++;
    total++; if (load_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", load_done); else pass_cnt++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr_adr = 8'h25; wr_en = 2'b11; wr_data = 8'h77; step();
    wr_en = 2'b01; wr_data = 8'hA5; step();
    wr_en = 2'b00; wr_data = 8'hFF; step();
    read_check(8'h25, 16'h77A5, "write_read_lane0");
    wr_en = 2'b10; wr_data = 8'h19; step();
    wr_en = 2'b00;
    read_check(8'h25, 16'h19A5, "write_read_lane1");
  endtask

  task automatic test_bypass();
    wr_adr = 8'h10; wr_en = 2'b11; wr_data = 8'h11; step();
    rd_adr = 8'h10; wr_en = 2'b11; wr_data = 8'h3C; step();
    total++; if (rd_data !== 16'h3C3C) $display("FAIL bypass_both: got %h expected 3c3c", rd_data); else pass_cnt++;
    wr_en = 2'b10; wr_data = 8'h5A; step();
    total++; if (rd_data !== 16'h5A3C) $display("FAIL bypass_lane1: got %h expected 5a3c", rd_data); else pass_cnt++;
    wr_en = 2'b00;
  endtask

  task automatic test_full_fill();
    int dones;
    dones = 0;
    load_start = 1'b1; load_bank = 3'd3; step();
    load_start = 1'b0;
    total++; if (load_busy !== 1'b1) $display("FAIL fill_busy: got %b expected 1", load_busy); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1; load_data = 16'(i * 16'h0101);
      total++; if (load_ready !== 1'b1) $display("FAIL fill_ready word %0d: got %b expected 1", i, load_ready); else pass_cnt++;
      if (load_done) dones++;
      step();
    end
    load_valid = 1'b0;
    total++; if (load_done !== 1'b1) $display("FAIL fill_done_pulse: got %b expected 1", load_done); else pass_cnt++;
    if (load_done) dones++;
    step();
    total++; if (load_busy !== 1'b0) $display("FAIL fill_idle_busy: got %b expected 0", load_busy); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (load_done) dones++;
      step();
    end
    total++; if (dones !== 1) $display("FAIL fill_done_count: got %0d expected 1", dones); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      read_check({3'd3, 5'(i)}, 16'(i * 16'h0101), "fill_readback");
    end
  endtask

  task automatic test_conflict();
    load_start = 1'b1; load_bank = 3'd3; step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 16'hAAAA;
    wr_adr = {3'd3, 5'd20}; wr_en = 2'b01; wr_data = 8'h11;
    #1;
    total++; if (load_ready !== 1'b0) $display("FAIL conflict_same_bank: got %b expected 0", load_ready); else pass_cnt++;
    step();
    wr_adr = {3'd2, 5'd0}; wr_en = 2'b01; wr_data = 8'h22;
    #1;
    total++; if (load_ready !== 1'b1) $display("FAIL conflict_other_bank: got %b expected 1", load_ready); else pass_cnt++;
    step();
    wr_en = 2'b00; load_valid = 1'b0;
  endtask

  task automatic test_start_ignored();
    load_start = 1'b1; load_bank = 3'd5; step();
    load_start = 1'b0;
    total++; if (load_busy !== 1'b1) $display("FAIL start_ignored_busy: got %b expected 1", load_busy); else pass_cnt++;
    load_valid = 1'b1; load_data = 16'hBBBB; step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int dones;
    dones = 0;
    for (int i = 2; i < 10; i++) begin
      load_valid = 1'b1; load_data = 16'(16'hC000 + i); step();
    end
    load_valid = 1'b0;
    reset = 1'b0; step();
    total++; if (load_busy !== 1'b0) $display("FAIL midfill_busy: got %b expected 0", load_busy); else pass_cnt++;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (load_done) dones++;
      step();
    end
    total++; if (dones !== 0) $display("FAIL midfill_no_done: got %0d expected 0", dones); else pass_cnt++;
    read_check({3'd3, 5'd0}, 16'hAAAA, "midfill_field0");
    read_check({3'd3, 5'd1}, 16'hBBBB, "midfill_field1");
    for (int i = 2; i < 10; i++) begin
      read_check({3'd3, 5'(i)}, 16'(16'hC000 + i), "midfill_field");
    end
    read_check({3'd3, 5'd10}, 16'h0A0A, "midfill_untouched");
    read_check({3'd3, 5'd20}, 16'h1411, "conflict_pat_write");
    rd_adr = {3'd2, 5'd0}; step();
    total++; if (rd_data[7:0] !== 8'h22) $display("FAIL conflict_bank2_write: got %h expected 22", rd_data[7:0]); else pass_cnt++;
    load_start = 1'b1; load_bank = 3'd1; step();
    load_start = 1'b0;
    total++; if (load_busy !== 1'b1) $display("FAIL restart_busy: got %b expected 1", load_busy); else pass_cnt++;
    total++; if (load_ready !== 1'b1) $display("FAIL restart_ready: got %b expected 1", load_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_full_fill();
    test_conflict();
    test_start_ignored();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
